conv_enc_framer: RTL

CONV_ENC_FRAMER -- requirements
Module: conv_enc_framer

---
 rtl/conv_enc_framer.sv | 105 ++++++++++
 1 files changed

// File: rtl/conv_enc_framer.sv
// Rate-1/2 K=3 convolutional encoder that frames a 4-bit message plus a
// 2-bit zero tail into one 12-bit codeword held until the consumer takes it.
module conv_enc_framer #(
  parameter logic [2:0] G0 = 3'b111,
  parameter logic [2:0] G1 = 3'b101
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  msg_in,
  input  logic        msg_valid,
  output logic        msg_ready,
  output logic [11:0] codeword,
  output logic        cw_valid,
  input  logic        cw_ready,
  output logic [7:0]  frame_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENCODE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  buf_q, buf_d;
  logic        d1_q, d1_d;
  logic        d2_q, d2_d;
  logic [2:0]  step_q, step_d;
  logic [11:0] acc_q, acc_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        u;
  logic [2:0]  taps;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      d1_q        <= 1'b0;
      d2_q        <= 1'b0;
      step_q      <= '0;
      acc_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      d1_q        <= d1_d;
      d2_q        <= d2_d;
      step_q      <= step_d;
      acc_q       <= acc_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    d1_d        = d1_q;
    d2_d        = d2_q;
    step_d      = step_q;
    acc_d       = acc_q;
    frame_cnt_d = frame_cnt_q;
    u           = 1'b0;
    taps        = 3'b000;
    case (state_q)
      IDLE: begin
        if (msg_valid) begin
          buf_d   = msg_in;
          d1_d    = 1'b0;
          d2_d    = 1'b0;
          step_d  = '0;
          acc_d   = '0;
          state_d = ENCODE;
        end
      end
      ENCODE: begin
        // Steps 4 and 5 flush the encoder memory with zeros.
        u      = (step_q < 3'd4) ? buf_q[3] : 1'b0;
        taps   = {u, d1_q, d2_q};
        buf_d  = {buf_q[2:0], 1'b0};
        acc_d  = {acc_q[9:0], ^(G0 & taps), ^(G1 & taps)};
        d2_d   = d1_q;
        d1_d   = u;
        step_d = step_q + 3'd1;
        if (step_q == 3'd5) begin
          step_d  = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (cw_ready) begin
          frame_cnt_d = frame_cnt_q + 8'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The accumulator is only exposed once the whole frame is complete.
  assign msg_ready = (state_q == IDLE) && !reset;
  assign cw_valid  = (state_q == HOLD);
  assign codeword  = (state_q == HOLD) ? acc_q : 12'h000;
  assign frame_cnt = frame_cnt_q;

endmodule
